load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles mem_req waits for mem_ack.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  access request, sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load.
REQ-006 addr  input  32  byte address from the ALU add result.
REQ-007 wdata  input  32  store data (rs2).
REQ-008 data_size  input  2  00 byte, 01 half, 10 word, 11 illegal (decoder encoding).
REQ-009 data_type  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  extended load result, valid while done is high.
REQ-013 misaligned  output  1  address/size fault, valid with done.
REQ-014 timeout  output  1  no-ack fault, valid with done.
REQ-015 mem_req, mem_we  output  1 each  memory request, write enable.
REQ-016 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-017 mem_be  output  4  byte-lane enables.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_ack  input  1  memory completion; mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-020 The block SHALL implement FSM states IDLE, REQ, DONE.
- IDLE: on start=1, latch is_store, addr, wdata, data_size, data_type.
- If the access is legal, go to REQ.
- If it is misaligned or illegal, go to DONE with misaligned=1.
REQ-021 An access SHALL be misaligned when any of the following holds:
- half with addr[0]=1;
- word with addr[1:0]!=0;
- data_size=11.
REQ-022 In REQ, mem_req, mem_addr, mem_be, mem_we and mem_wdata SHALL be registered and held stable until the cycle mem_ack=1 is sampled.
REQ-023 On mem_ack=1 in REQ, the block SHALL capture mem_rdata, drop mem_req in the next cycle, and enter DONE.
REQ-024 If TIMEOUT_CYCLES cycles elapse in REQ without mem_ack, the block SHALL drop mem_req and enter DONE with timeout=1; the wait counter SHALL be cleared on entering REQ.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a start during DONE SHALL be ignored.
REQ-026 A start while busy=1 SHALL be ignored, with no latching and no queueing.
REQ-027 mem_ack outside REQ SHALL be ignored.
REQ-028 Latency SHALL be as follows:
- mem_req asserts in the cycle after start.
- With ack on the first REQ cycle, done asserts two cycles after start.
- A misaligned access asserts done one cycle after start.
REQ-029 Store lane rules SHALL be:
- byte: mem_be = 4'b0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}};
- half: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}};
- word: mem_be = 1111, mem_wdata = wdata.
REQ-030 Loads SHALL drive mem_we=0 and the same mem_be as stores.
REQ-031 The load result SHALL be formed as follows:
- select the byte or half at lane addr[1:0];
- extend to 32 bits per data_type;
- pass a word through unchanged.
REQ-032 Stores SHALL produce rdata=0; a faulted access SHALL produce rdata=0; misaligned and timeout SHALL be 0 whenever done=0.
REQ-033 Misaligned accesses SHALL never assert mem_req.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE; busy, done, misaligned, timeout, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0; wait counter = 0.
REQ-035 Reset asserted mid-REQ SHALL drop mem_req immediately; the outstanding access SHALL be abandoned without done; a late mem_ack after reset release SHALL be ignored.

Verification
REQ-036 LB sign: addr=0x1003, size=00, type=0, mem_rdata=0x80FF_FFFF, ack first cycle -> mem_addr=0x1000, mem_be=1000, rdata=0xFFFF_FF80, done at start+2.
REQ-037 LHU: addr=0x2002, size=01, type=1, mem_rdata=0xBEEF_1234 -> mem_be=1100, rdata=0x0000_BEEF.
REQ-038 SB: addr=0x3001, wdata=0x1234_56AB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, rdata=0.
REQ-039 Misaligned SW: addr=0x4002, size=10 -> mem_req never 1, done and misaligned at start+1.
REQ-040 Timeout: mem_ack held 0 -> mem_req high 16 cycles, then done=1, timeout=1; a start issued while busy is ignored.
REQ-041 Reset mid-REQ, then ack -> mem_req 0 immediately; done never pulses; busy=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core-side request/response and memory-side bus bundle for load_store_unit.
// Rev 1.0 - initial release.
`default_nettype none

interface load_store_unit_if;
   logic        start;
   logic        is_store;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  data_size;
   logic        data_type;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic        timeout;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  start, is_store, addr, wdata, data_size, data_type, mem_ack, mem_rdata,
      output busy, done, rdata, misaligned, timeout,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output start, is_store, addr, wdata, data_size, data_type, mem_ack, mem_rdata,
      input  busy, done, rdata, misaligned, timeout,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: single-access LSU with lane steering, load extension, misalign and timeout faults.
// Rev 1.0 - initial release.
`default_nettype none

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input wire logic          clk,
   input wire logic          rst_n,
   load_store_unit_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_wait;
   logic          r_is_store, r_type, r_mis, r_tmo;
   logic [1:0]    r_size, r_lane;
   logic [31:0]   r_rdata;
   logic          r_mem_req, r_mem_we;
   logic [31:0]   r_mem_addr, r_mem_wdata;
   logic [3:0]    r_mem_be;

   logic          w_fault, w_ack_hit, w_expire;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata, w_load;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;

   assign w_fault   = (bus.data_size == 2'b11) ||
                      (bus.data_size == 2'b01 && bus.addr[0]) ||
                      (bus.data_size == 2'b10 && bus.addr[1:0] != 2'b00);
   assign w_ack_hit = (r_state == S_REQ) && bus.mem_ack;
   assign w_expire  = (r_state == S_REQ) && !bus.mem_ack && (r_wait == CW'(TIMEOUT_CYCLES - 1));

   // Lane steering is taken from the live inputs because it is registered on the accepting edge.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.wdata;
      case (bus.data_size)
         2'b00: begin
            w_be    = 4'b0001 << bus.addr[1:0];
            w_wdata = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = bus.mem_rdata[7:0];
      case (r_lane)
         2'd1:    w_byte = bus.mem_rdata[15:8];
         2'd2:    w_byte = bus.mem_rdata[23:16];
         2'd3:    w_byte = bus.mem_rdata[31:24];
         default: w_byte = bus.mem_rdata[7:0];
      endcase
      w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_size)
         2'b00:   w_load = {{24{~r_type & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{~r_type & w_half[15]}}, w_half};
         default: w_load = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = w_fault ? S_DONE : S_REQ;
         S_REQ:   if (w_ack_hit || w_expire) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait      <= '0;
         r_is_store  <= 1'b0;
         r_type      <= 1'b0;
         r_mis       <= 1'b0;
         r_tmo       <= 1'b0;
         r_size      <= 2'b00;
         r_lane      <= 2'b00;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_is_store <= bus.is_store;
               r_type     <= bus.data_type;
               r_size     <= bus.data_size;
               r_lane     <= bus.addr[1:0];
               r_mis      <= w_fault;
               r_tmo      <= 1'b0;
               r_rdata    <= '0;
               r_wait     <= '0;
               if (!w_fault) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= bus.is_store;
                  r_mem_addr  <= {bus.addr[31:2], 2'b00};
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
               end
            end
            S_REQ: begin
               if (w_ack_hit) begin
                  r_mem_req <= 1'b0;
                  r_rdata   <= r_is_store ? 32'd0 : w_load;
               end else if (w_expire) begin
                  r_mem_req <= 1'b0;
                  r_tmo     <= 1'b1;
               end else begin
                  r_wait <= r_wait + CW'(1);
               end
            end
            S_DONE: begin
               r_mis <= 1'b0;
               r_tmo <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.rdata      = r_rdata;
   assign bus.misaligned = bus.done & r_mis;
   assign bus.timeout    = bus.done & r_tmo;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_be     = r_mem_be;
   assign bus.mem_wdata  = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus timeout and mid-access reset sequences.
// Rev 1.0 - initial release.
`default_nettype none

module tb_load_store_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        typ;
      logic [31:0] mrd;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rd;
      logic        mis;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_start(input vec_t v);
      bus.start     = 1'b1;
      bus.is_store  = v.st;
      bus.addr      = v.addr;
      bus.wdata     = v.wdata;
      bus.data_size = v.size;
      bus.data_type = v.typ;
   endtask

   initial begin
      int          cnt;
      int          seen;
      logic [31:0] exp_addr;
      vec_t        v;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.is_store = 1'b0; bus.addr = '0; bus.wdata = '0;
      bus.data_size = 2'b00; bus.data_type = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

      //          st    addr          wdata         sz     ty    mem_rdata     be       mem_wdata     rdata         mis
      vecs[0]  = '{1'b0, 32'h0000_1003, 32'h0,        2'b00, 1'b0, 32'h80FF_FFFF, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b1, 32'hBEEF_1234, 4'b1100, 32'h0,        32'h0000_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_3001, 32'h1234_56AB, 2'b00, 1'b0, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h0000_5000, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_6000, 32'h0,        2'b01, 1'b0, 32'h1234_8001, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_7001, 32'h0,        2'b00, 1'b1, 32'h0000_A500, 4'b0010, 32'h0,        32'h0000_00A5, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_8002, 32'hCAFE_1234, 2'b01, 1'b0, 32'h5555_5555, 4'b1100, 32'h1234_1234, 32'h0,        1'b0};
      vecs[7]  = '{1'b1, 32'h0000_9000, 32'h0102_0304, 2'b10, 1'b0, 32'h5555_5555, 4'b1111, 32'h0102_0304, 32'h0,        1'b0};
      vecs[8]  = '{1'b1, 32'h0000_4002, 32'h1111_2222, 2'b10, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[9]  = '{1'b0, 32'h0000_4001, 32'h0,        2'b01, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[10] = '{1'b0, 32'h0000_4000, 32'h0,        2'b11, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

      repeat (2) @(negedge clk);
      chk("rst_busy",   {31'd0, bus.busy},       32'd0);
      chk("rst_done",   {31'd0, bus.done},       32'd0);
      chk("rst_memreq", {31'd0, bus.mem_req},    32'd0);
      chk("rst_memaddr", bus.mem_addr,           32'd0);
      chk("rst_membe",  {28'd0, bus.mem_be},     32'd0);
      chk("rst_memwd",  bus.mem_wdata,           32'd0);
      chk("rst_rdata",  bus.rdata,               32'd0);
      chk("rst_faults", {30'd0, bus.misaligned, bus.timeout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         exp_addr = {v.addr[31:2], 2'b00};
         drive_start(v);
         @(negedge clk);
         bus.start = 1'b0;
         chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
         if (v.mis) begin
            chk($sformatf("v%0d_memreq", i), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d_done", i), {31'd0, bus.done}, 32'd1);
            chk($sformatf("v%0d_mis", i), {31'd0, bus.misaligned}, 32'd1);
            chk($sformatf("v%0d_rdata", i), bus.rdata, 32'd0);
         end else begin
            chk($sformatf("v%0d_memreq", i), {31'd0, bus.mem_req}, 32'd1);
            chk($sformatf("v%0d_done_early", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("v%0d_memaddr", i), bus.mem_addr, exp_addr);
            chk($sformatf("v%0d_membe", i), {28'd0, bus.mem_be}, {28'd0, v.be});
            chk($sformatf("v%0d_memwe", i), {31'd0, bus.mem_we}, {31'd0, v.st});
            if (v.st) chk($sformatf("v%0d_memwdata", i), bus.mem_wdata, v.mwd);
            bus.mem_ack = 1'b1;
            bus.mem_rdata = v.mrd;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 32'h0;
            chk($sformatf("v%0d_done", i), {31'd0, bus.done}, 32'd1);
            chk($sformatf("v%0d_rdata", i), bus.rdata, v.rd);
            chk($sformatf("v%0d_memreq_drop", i), {31'd0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d_faults", i), {30'd0, bus.misaligned, bus.timeout}, 32'd0);
         end
         @(negedge clk);
         chk($sformatf("v%0d_idle_done", i), {31'd0, bus.done}, 32'd0);
         chk($sformatf("v%0d_idle_busy", i), {31'd0, bus.busy}, 32'd0);
         chk($sformatf("v%0d_idle_faults", i), {30'd0, bus.misaligned, bus.timeout}, 32'd0);
      end

      // Stray ack while idle must not produce a completion.
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("idle_ack_done", {31'd0, bus.done}, 32'd0);
      chk("idle_ack_busy", {31'd0, bus.busy}, 32'd0);

      // Timeout with a start issued while busy.
      v = '{1'b0, 32'h0000_A000, 32'h0, 2'b10, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0};
      drive_start(v);
      @(negedge clk);
      bus.start = 1'b0;
      cnt = 0;
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         if (bus.done) seen = 1;
         else begin
            if (bus.mem_req) cnt++;
            if (c == 5) begin
               bus.start = 1'b1; bus.addr = 32'h0000_C004; bus.is_store = 1'b1;
            end
            if (c == 6) bus.start = 1'b0;
            @(negedge clk);
         end
      end
      chk("tmo_done_seen", seen, 1);
      chk("tmo_req_cycles", cnt, 16);
      chk("tmo_flag", {31'd0, bus.timeout}, 32'd1);
      chk("tmo_mis", {31'd0, bus.misaligned}, 32'd0);
      chk("tmo_rdata", bus.rdata, 32'd0);
      chk("tmo_memreq", {31'd0, bus.mem_req}, 32'd0);
      chk("tmo_addr_kept", bus.mem_addr, 32'h0000_A000);
      chk("tmo_we_kept", {31'd0, bus.mem_we}, 32'd0);
      // Start during DONE must be dropped.
      bus.start = 1'b1; bus.addr = 32'h0000_D000; bus.is_store = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_start_busy", {31'd0, bus.busy}, 32'd0);
      chk("done_start_req", {31'd0, bus.mem_req}, 32'd0);
      chk("tmo_flag_clear", {31'd0, bus.timeout}, 32'd0);
      @(negedge clk);
      chk("done_start_busy2", {31'd0, bus.busy}, 32'd0);

      // Reset in the middle of REQ, then a late ack.
      v = '{1'b0, 32'h0000_B000, 32'h0, 2'b10, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0};
      drive_start(v);
      @(negedge clk);
      bus.start = 1'b0;
      chk("rr_memreq", {31'd0, bus.mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_memreq_async", {31'd0, bus.mem_req}, 32'd0);
      chk("rr_busy_async", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.mem_req) seen = 1;
      end
      bus.mem_ack = 1'b0;
      chk("rr_no_activity", seen, 0);
      chk("rr_rdata", bus.rdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
